// File: rtl/cache_op_ctrl.sv
// ============================================================================
// cache_op_ctrl : WR-stage CACHE instruction sequencer to I/D maintenance ports
// Optional watchdog: CACHE_OP_TIMEOUT_EN               Revision 1.0
// ============================================================================
`default_nettype none

module cache_op_ctrl #(
  parameter int LINE_OFF       = 5,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [4:0]  WR_cache_op_i,
  input  logic [31:0] WR_cache_paddr_i,
  input  logic [1:0]  WR_cache_target_i,
  output logic        cache_op_done,
  output logic        ic_op_req,
  output logic [2:0]  ic_op_code,
  output logic [31:0] ic_op_addr,
  input  logic        ic_op_ack,
  output logic        dc_op_req,
  output logic [2:0]  dc_op_code,
  output logic [31:0] dc_op_addr,
  input  logic        dc_op_ack,
  output logic        op_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [1:0] TGT_IC = 2'b01;
  localparam logic [1:0] TGT_DC = 2'b10;
  localparam logic [1:0] TGT_RS = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [2:0]  code_q, code_d;
  logic [31:0] addr_q, addr_d;
  logic        abort_q, abort_d;
  logic        ack_w;
  logic        tmo_w;
  logic        unused_ok;

  assign ack_w     = (tgt_q == TGT_IC) ? ic_op_ack : dc_op_ack;
  assign unused_ok = ^{WR_cache_op_i[1:0], WR_cache_paddr_i[LINE_OFF-1:0]};

`ifdef CACHE_OP_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_flag_q, tmo_flag_d;

  // Counter sits at zero outside REQ, so it is already clear on REQ entry.
  assign tmo_w = (state_q == REQ) && !ack_w && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d      = (state_q == REQ) ? cnt_q + 1'b1 : '0;
    tmo_flag_d = tmo_flag_q | tmo_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign op_timeout = tmo_flag_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign tmo_w      = 1'b0;
  assign op_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    code_d  = code_q;
    addr_d  = addr_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (WR_cache_target_i == TGT_IC || WR_cache_target_i == TGT_DC) begin
            tgt_d   = WR_cache_target_i;
            code_d  = WR_cache_op_i[4:2];
            addr_d  = {WR_cache_paddr_i[31:LINE_OFF], {LINE_OFF{1'b0}}};
            abort_d = 1'b0;
            state_d = REQ;
          end else if (WR_cache_target_i == TGT_RS) begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        // The request is never withdrawn early; a flush only suppresses the done pulse.
        if (ack_w || tmo_w) begin
          state_d = (abort_q || flush) ? IDLE : DONE;
        end else if (flush) begin
          abort_d = 1'b1;
        end
      end
      DONE: state_d = flush ? IDLE : HOLD;
      HOLD: begin
        if (WR_cache_target_i == 2'b00 || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_q   <= 2'b00;
      code_q  <= 3'b000;
      addr_q  <= 32'h0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      abort_q <= abort_d;
    end
  end

  assign ic_op_req     = (state_q == REQ) && (tgt_q == TGT_IC);
  assign dc_op_req     = (state_q == REQ) && (tgt_q == TGT_DC);
  assign ic_op_code    = code_q;
  assign dc_op_code    = code_q;
  assign ic_op_addr    = addr_q;
  assign dc_op_addr    = addr_q;
  assign cache_op_done = (state_q == DONE) && !flush;

endmodule

`default_nettype wire

// File: doc/cache_op_ctrl.md
# cache_op_ctrl

Sequencer between the WR-stage CACHE-instruction interface and the I/D cache maintenance ports. It latches the level-held request from WR (op, physical address, target) and issues exactly one maintenance transaction to the selected cache. It then returns a one-cycle `cache_op_done` pulse and re-arms only after WR drops the request. Flushes are absorbed without ever abandoning a transaction the cache has already seen.

## Interface
Parameters:
- `LINE_OFF`, 5: line-offset bits cleared from the issued address.
- `TIMEOUT_CYCLES`, 1023: watchdog limit, used only with `CACHE_OP_TIMEOUT_EN`.

Ports:
- `clk`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high.
- `flush`  in  1: WR flush (exception/eret/refetch/wait).
- `WR_cache_op_i`  in  5: [4:2] op type, [1:0] cache select field.
- `WR_cache_paddr_i`  in  32: physical address.
- `WR_cache_target_i`  in  2: 01 icache, 10 dcache, 00 idle, 11 reserved; held by WR while waiting.
- `cache_op_done`  out  1: one-cycle completion pulse to WR.
- `ic_op_req`  out  1: icache request.
- `ic_op_code`  out  3: op type to icache.
- `ic_op_addr`  out  32: line-aligned address to icache.
- `ic_op_ack`  in  1: icache accept/complete.
- `dc_op_req`  out  1: dcache request.
- `dc_op_code`  out  3: op type to dcache.
- `dc_op_addr`  out  32: line-aligned address to dcache.
- `dc_op_ack`  in  1: dcache accept/complete.
- `op_timeout`  out  1: sticky watchdog flag (only with `CACHE_OP_TIMEOUT_EN`; tied 0 otherwise).

## Operation
- States: IDLE, REQ, DONE, HOLD.
- IDLE:
  - `WR_cache_target_i` ∈ {01,10} and !`flush` → latch op[4:2], target and `{paddr[31:LINE_OFF], LINE_OFF'b0}`; go REQ.
  - Target 11 → no cache request; go DONE.
- REQ:
  - `req` of the latched target is high; the other cache's `req` is low.
  - `code` and `addr` are stable for the whole request.
  - `ack` sampled high → go DONE.
  - `req` is never withdrawn before `ack`, even under flush.
- Abort:
  - `flush` seen in REQ sets the `abort` bit.
  - On `ack` with `abort` set, go IDLE directly; no done pulse.
- DONE:
  - `cache_op_done`=1 for exactly this cycle, unless `flush` is high this cycle, in which case it is 0.
  - Go HOLD, or IDLE if `flush`.
- HOLD:
  - Wait for `WR_cache_target_i`==00 or `flush`, then go IDLE.
  - Guarantees one transaction per WR request.
- Op types with no meaning for the selected cache (e.g. writeback ops to icache) are still forwarded; the cache defines them as nops and must still ack.
- Reset values: all outputs 0; state IDLE; `abort` 0; `op_timeout` 0.

## Timing
- T0: target valid in IDLE.
- T1: `req` high (registered).
- Tn: `ack` high, earliest at T1.
- Tn+1: `cache_op_done` high.
- Tn+2: WR leaves INCACHE1 and target reads 00.
- Tn+3: state is IDLE again.
- Minimum done latency is 2 cycles from target assertion; reserved target gives done at T1.
- `flush` in IDLE, or simultaneous with a new target in IDLE → no latch, stay IDLE.
- `reset` mid-REQ → immediate IDLE, `req` low next cycle. The caches must tolerate this, as they are reset too.
- Simultaneous `ack` and `flush` in REQ → treated as abort: IDLE, no done.

## Configuration
- `CACHE_OP_TIMEOUT_EN` defined:
  - A 10-bit-minimum counter (width = clog2(`TIMEOUT_CYCLES`+1)) counts cycles spent in REQ and clears on entry to REQ.
  - When the count reaches `TIMEOUT_CYCLES` with no `ack`, `req` drops and the state goes DONE (done pulse unless aborted).
  - `op_timeout` is set and stays set until `reset`.
- `CACHE_OP_TIMEOUT_EN` undefined:
  - No counter; REQ waits indefinitely.
  - `op_timeout` is constant 0.

## Test plan
- Dcache op: target=10, op=5'b10101, paddr=0x1234_567C, `dc_op_ack` two cycles after `req` → `dc_op_addr`=0x1234_5660, `dc_op_code`=3'b101, `ic_op_req` stays 0, exactly one done pulse 1 cycle after ack.
- Icache op: target=01 held 3 cycles past done (slow WR) → exactly one `ic_op_req` transaction and one done pulse; no reissue during HOLD.
- Flush in REQ: assert `flush` for 1 cycle while `ic_op_req`=1, ack 3 cycles later → `req` held until ack, no done, IDLE next cycle.
- Reserved target: target=11 → done at T1, neither `req` asserted.
- Back-to-back: second target=10 asserted the cycle after the state returns to IDLE → second transaction issued, two done pulses total.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): ack never arrives → `req` drops after 8 cycles in REQ, done pulse, `op_timeout`=1 until reset.
